// File: rtl/trap_ctrl_if.sv
// ============================================================================
// Module      : trap_ctrl_if
// Description : Decode/execute and CSR-file signal bundle for the trap sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_ctrl_if;
    logic        instr_valid_i;
    logic [31:0] pc_i;
    logic        illegal_i;
    logic        ebreak_i;
    logic        ecall_i;
    logic        mret_i;
    logic        irq_i;
    logic        mie_i;
    logic [31:0] epc_i;
    logic        save_epc_o;
    logic [31:0] epc_pc_o;
    logic [31:0] cause_o;
    logic        stall_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    modport master (
        output instr_valid_i, pc_i, illegal_i, ebreak_i, ecall_i, mret_i,
               irq_i, mie_i, epc_i,
        input  save_epc_o, epc_pc_o, cause_o, stall_o, redirect_o, redirect_pc_o
    );

    modport slave (
        input  instr_valid_i, pc_i, illegal_i, ebreak_i, ecall_i, mret_i,
               irq_i, mie_i, epc_i,
        output save_epc_o, epc_pc_o, cause_o, stall_o, redirect_o, redirect_pc_o
    );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer: EPC save, flush stall, redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl #(
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010,
    parameter int          FLUSH_CYCLES = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    trap_ctrl_if.slave  bus
);

    localparam logic [3:0]  c_flush_load   = 4'(FLUSH_CYCLES - 1);
    localparam logic [31:0] c_cause_ill    = 32'h0000_0002;
    localparam logic [31:0] c_cause_ebreak = 32'h0000_0003;
    localparam logic [31:0] c_cause_ecall  = 32'h0000_000B;
    localparam logic [31:0] c_cause_irq    = 32'h8000_000B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP     = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_irq_meta;
    logic        r_irq_s;
    logic [3:0]  r_cnt;
    logic        r_mret;
    logic [31:0] r_epc_pc;
    logic [31:0] r_cause;
    logic [31:0] r_redirect_pc;
    logic        w_take_trap;
    logic        w_take_mret;
    logic [31:0] w_cause;
    logic [31:0] w_redirect_target;

    // Two-flop synchronizer; the level is not latched, so a short pulse can be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_meta <= 1'b0;
            r_irq_s    <= 1'b0;
        end else begin
            r_irq_meta <= bus.irq_i;
            r_irq_s    <= r_irq_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take_trap = 1'b0;
        w_take_mret = 1'b0;
        w_cause     = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.instr_valid_i) begin
                    if (bus.illegal_i) begin
                        w_take_trap = 1'b1;
                        w_cause     = c_cause_ill;
                    end else if (bus.ebreak_i) begin
                        w_take_trap = 1'b1;
                        w_cause     = c_cause_ebreak;
                    end else if (bus.ecall_i) begin
                        w_take_trap = 1'b1;
                        w_cause     = c_cause_ecall;
                    end else if (r_irq_s && bus.mie_i) begin
                        w_take_trap = 1'b1;
                        w_cause     = c_cause_irq;
                    end else if (bus.mret_i) begin
                        w_take_mret = 1'b1;
                    end
                end
                if (w_take_trap) begin
                    w_state_nxt = ST_TRAP;
                end else if (w_take_mret) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_TRAP:     w_state_nxt = ST_FLUSH;
            ST_FLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter is loaded only on FLUSH entry, so it never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= 4'd0;
            r_mret        <= 1'b0;
            r_epc_pc      <= '0;
            r_cause       <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (r_state == ST_TRAP || w_take_mret) begin
                r_cnt <= c_flush_load;
            end else if (r_state == ST_FLUSH && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_take_trap) begin
                r_epc_pc <= bus.pc_i;
                r_cause  <= w_cause;
                r_mret   <= 1'b0;
            end else if (w_take_mret) begin
                r_mret   <= 1'b1;
            end
            if (r_state == ST_REDIRECT) begin
                r_redirect_pc <= w_redirect_target;
            end
        end
    end

    // mret returns to mepc as it reads in the redirect cycle itself.
    assign w_redirect_target = r_mret ? bus.epc_i : TRAP_VECTOR;

    assign bus.save_epc_o    = (r_state == ST_TRAP);
    assign bus.stall_o       = (r_state != ST_IDLE);
    assign bus.redirect_o    = (r_state == ST_REDIRECT);
    assign bus.redirect_pc_o = (r_state == ST_REDIRECT) ? w_redirect_target : r_redirect_pc;
    assign bus.epc_pc_o      = r_epc_pc;
    assign bus.cause_o       = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl (FLUSH_CYCLES 2 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    trap_ctrl_if bus ();
    trap_ctrl_if bus4 ();

    trap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    trap_ctrl #(.TRAP_VECTOR(32'h0000_0010), .FLUSH_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.instr_valid_i = 1'b0; bus.pc_i = '0; bus.illegal_i = 1'b0;
        bus.ebreak_i = 1'b0; bus.ecall_i = 1'b0; bus.mret_i = 1'b0;
        bus.irq_i = 1'b0; bus.mie_i = 1'b0;
        bus4.instr_valid_i = 1'b0; bus4.pc_i = '0; bus4.illegal_i = 1'b0;
        bus4.ebreak_i = 1'b0; bus4.ecall_i = 1'b0; bus4.mret_i = 1'b0;
        bus4.irq_i = 1'b0; bus4.mie_i = 1'b0; bus4.epc_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.epc_i = '0;
        #1;
        checks++;
        if ({bus.save_epc_o, bus.stall_o, bus.redirect_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000", {bus.save_epc_o, bus.stall_o, bus.redirect_o});
        end
        checks++;
        if ({bus.epc_pc_o, bus.cause_o, bus.redirect_pc_o} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: epc %h cause %h rpc %h want 0", bus.epc_pc_o, bus.cause_o, bus.redirect_pc_o);
        end
        step();
        step();
        #3 rst = 1'b0;
        step();
    endtask

    task automatic test_ecall();
        bus.instr_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.pc_i = 32'h100;
        step();  // cycle N+1
        clear_inputs();
        checks++;
        if (bus.save_epc_o !== 1'b1 || bus.stall_o !== 1'b1 || bus.redirect_o !== 1'b0) begin
            errors++;
            $display("FAIL ecall_trap_cycle: save %b stall %b redir %b want 1 1 0", bus.save_epc_o, bus.stall_o, bus.redirect_o);
        end
        checks++;
        if (bus.epc_pc_o !== 32'h100 || bus.cause_o !== 32'hB) begin
            errors++;
            $display("FAIL ecall_epc_cause: epc %h cause %h want 100 b", bus.epc_pc_o, bus.cause_o);
        end
        for (int i = 2; i <= 3; i++) begin
            step();
            checks++;
            if (bus.stall_o !== 1'b1 || bus.save_epc_o !== 1'b0 || bus.redirect_o !== 1'b0) begin
                errors++;
                $display("FAIL ecall_flush_n%0d: stall %b save %b redir %b want 1 0 0", i, bus.stall_o, bus.save_epc_o, bus.redirect_o);
            end
        end
        step();  // N+4
        checks++;
        if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h10 || bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL ecall_redirect: redir %b pc %h stall %b want 1 10 1", bus.redirect_o, bus.redirect_pc_o, bus.stall_o);
        end
        step();  // N+5
        checks++;
        if (bus.stall_o !== 1'b0 || bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'h10) begin
            errors++;
            $display("FAIL ecall_idle: stall %b redir %b pc %h want 0 0 10", bus.stall_o, bus.redirect_o, bus.redirect_pc_o);
        end
    endtask

    task automatic test_priority();
        int saves;
        int redirs;
        bus.irq_i = 1'b1; bus.mie_i = 1'b1;
        step(); step(); step();
        bus.instr_valid_i = 1'b1; bus.illegal_i = 1'b1; bus.ebreak_i = 1'b1;
        bus.ecall_i = 1'b1; bus.pc_i = 32'h200;
        step();
        clear_inputs();
        checks++;
        if (bus.save_epc_o !== 1'b1 || bus.cause_o !== 32'h2 || bus.epc_pc_o !== 32'h200) begin
            errors++;
            $display("FAIL prio_cause: save %b cause %h epc %h want 1 2 200", bus.save_epc_o, bus.cause_o, bus.epc_pc_o);
        end
        saves = 0; redirs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            saves  += int'(bus.save_epc_o);
            redirs += int'(bus.redirect_o);
        end
        checks++;
        if (saves != 0 || redirs != 1) begin
            errors++;
            $display("FAIL prio_single_trap: extra saves %0d redirects %0d want 0 1", saves, redirs);
        end
    endtask

    task automatic test_irq_masked();
        int saves;
        int stalls;
        bus.irq_i = 1'b1; bus.mie_i = 1'b0; bus.instr_valid_i = 1'b1; bus.pc_i = 32'h80;
        saves = 0; stalls = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            saves  += int'(bus.save_epc_o);
            stalls += int'(bus.stall_o);
        end
        checks++;
        if (saves != 0 || stalls != 0) begin
            errors++;
            $display("FAIL irq_masked: saves %0d stalls %0d want 0 0", saves, stalls);
        end
        bus.mie_i = 1'b1; bus.pc_i = 32'h40;
        step();
        clear_inputs();
        checks++;
        if (bus.save_epc_o !== 1'b1 || bus.cause_o !== 32'h8000_000B || bus.epc_pc_o !== 32'h40) begin
            errors++;
            $display("FAIL irq_taken: save %b cause %h epc %h want 1 8000000b 40", bus.save_epc_o, bus.cause_o, bus.epc_pc_o);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_mret();
        bus.epc_i = 32'h104;
        bus.instr_valid_i = 1'b1; bus.mret_i = 1'b1; bus.pc_i = 32'h50;
        step();  // N+1
        clear_inputs();
        checks++;
        if (bus.save_epc_o !== 1'b0 || bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL mret_no_save: save %b stall %b want 0 1", bus.save_epc_o, bus.stall_o);
        end
        checks++;
        if (bus.cause_o !== 32'h8000_000B || bus.epc_pc_o !== 32'h40) begin
            errors++;
            $display("FAIL mret_keep_state: cause %h epc %h want 8000000b 40", bus.cause_o, bus.epc_pc_o);
        end
        step();  // N+2
        checks++;
        if (bus.stall_o !== 1'b1 || bus.redirect_o !== 1'b0) begin
            errors++;
            $display("FAIL mret_flush: stall %b redir %b want 1 0", bus.stall_o, bus.redirect_o);
        end
        step();  // N+3
        checks++;
        if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h104) begin
            errors++;
            $display("FAIL mret_redirect: redir %b pc %h want 1 104", bus.redirect_o, bus.redirect_pc_o);
        end
        step();  // N+4
        bus.epc_i = 32'h0;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0 || bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'h104) begin
            errors++;
            $display("FAIL mret_hold_pc: stall %b redir %b pc %h want 0 0 104", bus.stall_o, bus.redirect_o, bus.redirect_pc_o);
        end
    endtask

    task automatic test_ecall_during_flush();
        int saves;
        int redirs;
        bus.instr_valid_i = 1'b1; bus.ecall_i = 1'b1; bus.pc_i = 32'h300;
        step();  // N+1
        saves = 0; redirs = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 1) bus.pc_i = 32'h400;
            if (i == 4) clear_inputs();
            #1;
            saves  += int'(bus.save_epc_o);
            redirs += int'(bus.redirect_o);
            step();
        end
        checks++;
        if (saves != 1 || redirs != 1) begin
            errors++;
            $display("FAIL flush_ignore_pulses: saves %0d redirects %0d want 1 1", saves, redirs);
        end
        checks++;
        if (bus.epc_pc_o !== 32'h300) begin
            errors++;
            $display("FAIL flush_ignore_epc: epc %h want 300", bus.epc_pc_o);
        end
    endtask

    task automatic test_reset_in_flush();
        int pulses;
        bus4.instr_valid_i = 1'b1; bus4.ecall_i = 1'b1; bus4.pc_i = 32'h500;
        step();  // N+1 TRAP
        clear_inputs();
        step();  // N+2 FLUSH
        step();  // N+3 FLUSH
        checks++;
        if (bus4.stall_o !== 1'b1 || bus4.epc_pc_o !== 32'h500) begin
            errors++;
            $display("FAIL rstflush_pre: stall %b epc %h want 1 500", bus4.stall_o, bus4.epc_pc_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus4.save_epc_o, bus4.stall_o, bus4.redirect_o} !== 3'b000 ||
            {bus4.epc_pc_o, bus4.cause_o, bus4.redirect_pc_o} !== 96'd0) begin
            errors++;
            $display("FAIL rstflush_async: strobes %b epc %h cause %h rpc %h want 0",
                     {bus4.save_epc_o, bus4.stall_o, bus4.redirect_o}, bus4.epc_pc_o, bus4.cause_o, bus4.redirect_pc_o);
        end
        step();
        #3 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(bus4.redirect_o) + int'(bus4.save_epc_o) + int'(bus4.stall_o);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rstflush_after: %0d active output cycles want 0", pulses);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ecall();
        test_priority();
        test_irq_masked();
        test_mret();
        test_ecall_during_flush();
        test_reset_in_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
